// File: rtl/single_pc_ctrl_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, next-PC select codes
// and the instruction step size.
package single_pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_PLUS4  = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_JR     = 3'd3,
        SEL_TRAP   = 3'd4
    } pc_sel_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Instructions are word aligned; redirect targets drop their byte offset.
    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/single_next_pc_sel.sv
// Combinational next-PC priority mux: trap > jr > jump > branch > PC+4.
// Trap leg exists only when PC_TRAP_EN is defined.
module single_next_pc_sel
    import single_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0180
) (
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
`ifdef PC_TRAP_EN
    input  logic        trap,
`endif
    output logic [31:0] next_pc
);

    pc_sel_t sel;

    always_comb begin
        sel = SEL_PLUS4;
`ifdef PC_TRAP_EN
        if (trap)              sel = SEL_TRAP;
        else if (jr)           sel = SEL_JR;
`else
        if (jr)                sel = SEL_JR;
`endif
        else if (jump)         sel = SEL_JUMP;
        else if (branch_taken) sel = SEL_BRANCH;
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            SEL_TRAP:   next_pc = pc_align(TRAP_VECTOR);
            SEL_JR:     next_pc = pc_align(jr_target);
            SEL_JUMP:   next_pc = pc_align(jump_target);
            SEL_BRANCH: next_pc = pc_align(branch_target);
            default:    next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/single_pc_ctrl.sv
// Program-counter sequencer: PC register, BOOT/FETCH/EXEC/HALT fetch FSM, next-PC select.
// Optional trap redirect and EPC capture enabled by defining PC_TRAP_EN.
module single_pc_ctrl
    import single_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_halt,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    input  logic        i_trap,
    input  logic        i_imem_ack,
    output logic        o_imem_req,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_instr_valid,
    output logic        o_halted,
    output logic [31:0] o_epc
);

    pc_state_t   state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        exec_go;

    // Redirects, halt and trap only take effect on an unstalled EXEC cycle.
    assign exec_go = (state_reg == ST_EXEC) && !i_stall;

    assign o_pc_plus4 = pc_reg + PC_STEP;

    single_next_pc_sel #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_next_pc_sel (
        .pc_plus4      (o_pc_plus4),
        .branch_taken  (i_branch_taken),
        .branch_target (i_branch_target),
        .jump          (i_jump),
        .jump_target   (i_jump_target),
        .jr            (i_jr),
        .jr_target     (i_jr_target),
`ifdef PC_TRAP_EN
        .trap          (i_trap),
`endif
        .next_pc       (pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BOOT;
            pc_reg    <= RESET_VECTOR;
        end else begin
            state_reg <= state_next;
            if (exec_go)
                pc_reg <= pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BOOT:  state_next = ST_FETCH;
            ST_FETCH: if (i_imem_ack) state_next = ST_EXEC;
            ST_EXEC:  if (!i_stall) state_next = i_halt ? ST_HALT : ST_FETCH;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_BOOT;
        endcase
    end

    assign o_pc          = pc_reg;
    assign o_imem_req    = (state_reg == ST_FETCH);
    assign o_instr_valid = (state_reg == ST_EXEC);
    assign o_halted      = (state_reg == ST_HALT);

`ifdef PC_TRAP_EN
    logic [31:0] epc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            epc_reg <= '0;
        else if (exec_go && i_trap)
            epc_reg <= pc_reg;
    end

    assign o_epc = epc_reg;
`else
    logic unused_trap;
    assign unused_trap = i_trap;
    assign o_epc       = '0;
`endif

endmodule

// File: tb/tb_single_pc_ctrl.sv
// Directed bench for single_pc_ctrl: sequential fetch, redirect priority, alignment,
// wrap, ack wait, stall+halt, async reset mid-fetch, and trap (when PC_TRAP_EN is defined).
`timescale 1ns/1ps
module tb_single_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_stall, i_halt;
    logic        i_branch_taken, i_jump, i_jr, i_trap, i_imem_ack;
    logic [31:0] i_branch_target, i_jump_target, i_jr_target;
    logic        o_imem_req, o_instr_valid, o_halted;
    logic [31:0] o_pc, o_pc_plus4, o_epc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    single_pc_ctrl #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0180)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_stall         (i_stall),
        .i_halt          (i_halt),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_jr            (i_jr),
        .i_jr_target     (i_jr_target),
        .i_trap          (i_trap),
        .i_imem_ack      (i_imem_ack),
        .o_imem_req      (o_imem_req),
        .o_pc            (o_pc),
        .o_pc_plus4      (o_pc_plus4),
        .o_instr_valid   (o_instr_valid),
        .o_halted        (o_halted),
        .o_epc           (o_epc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_redirects();
        i_branch_taken = 1'b0;
        i_jump         = 1'b0;
        i_jr           = 1'b0;
        i_trap         = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        i_stall = 1'b0; i_halt = 1'b0; i_imem_ack = 1'b1;
        i_branch_target = '0; i_jump_target = '0; i_jr_target = '0;
        clear_redirects();

        @(negedge clk);
        check("rst_pc",     o_pc, 32'h0);
        check("rst_req",    o_imem_req, 0);
        check("rst_valid",  o_instr_valid, 0);
        check("rst_halted", o_halted, 0);
        check("rst_epc",    o_epc, 32'h0);
        rst_n = 1'b1;

        step();
        check("boot_fetch_req",   o_imem_req, 1);
        check("boot_fetch_valid", o_instr_valid, 0);

        // Sequential fetch: PC 0,4,8,C, valid every second cycle.
        for (int k = 0; k < 4; k++) begin
            step();
            check("seq_exec_valid", o_instr_valid, 1);
            check("seq_exec_pc", o_pc, 32'(k * 4));
            check("seq_exec_req", o_imem_req, 0);
            if (k < 3) begin
                step();
                check("seq_fetch_valid", o_instr_valid, 0);
            end
        end

        // Jump beats branch.
        i_branch_taken = 1'b1; i_branch_target = 32'h40;
        i_jump = 1'b1; i_jump_target = 32'h80;
        step();
        check("jump_over_branch", o_pc, 32'h80);
        clear_redirects();
        step();
        check("jump_exec_valid", o_instr_valid, 1);

        // jr beats jump; target aligned.
        i_jr = 1'b1; i_jr_target = 32'h103;
        i_jump = 1'b1; i_jump_target = 32'h200;
        step();
        check("jr_pc", o_pc, 32'h100);
        check("jr_plus4", o_pc_plus4, 32'h104);
        clear_redirects();
        step();

        // Wrap at the top of the address space.
        i_jump = 1'b1; i_jump_target = 32'hFFFF_FFFC;
        step();
        check("wrap_pc_top", o_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", o_pc_plus4, 32'h0);
        clear_redirects();
        step();
        step();
        check("wrap_pc_zero", o_pc, 32'h0);
        step();

        // Branch target alignment.
        i_branch_taken = 1'b1; i_branch_target = 32'h47;
        step();
        check("branch_align", o_pc, 32'h44);
        clear_redirects();
        step();

        // Ack wait: FETCH holds until ack; ack in EXEC irrelevant.
        i_imem_ack = 1'b0;
        step();
        check("ackwait_pc", o_pc, 32'h48);
        step();
        check("ackwait_req", o_imem_req, 1);
        check("ackwait_valid", o_instr_valid, 0);
        i_imem_ack = 1'b1;
        step();
        check("ackwait_exec", o_instr_valid, 1);

        // Stall 3 cycles with halt: PC held, then HALT.
        i_stall = 1'b1; i_halt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_valid", o_instr_valid, 1);
            check("stall_pc", o_pc, 32'h48);
        end
        i_stall = 1'b0;
        step();
        check("halt_flag", o_halted, 1);
        check("halt_valid", o_instr_valid, 0);
        check("halt_pc", o_pc, 32'h4C);
        i_halt = 1'b0;
        step();
        step();
        check("halt_stays", o_halted, 1);
        check("halt_noreq", o_imem_req, 0);

        // Async reset while FETCH waits for ack.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        i_jump = 1'b1; i_jump_target = 32'h20;
        i_imem_ack = 1'b0;
        step();
        clear_redirects();
        check("prereset_pc", o_pc, 32'h20);
        step();
        check("prereset_req", o_imem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", o_pc, 32'h0);
        check("async_rst_req", o_imem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        i_imem_ack = 1'b1;

        // Trap at PC 0x20 competing with jr.
        step();
        step();
        i_jump = 1'b1; i_jump_target = 32'h20;
        step();
        clear_redirects();
        step();
        check("trap_setup_pc", o_pc, 32'h20);
        i_trap = 1'b1; i_jr = 1'b1; i_jr_target = 32'h500;
        step();
        clear_redirects();
`ifdef PC_TRAP_EN
        check("trap_pc", o_pc, 32'h180);
        check("trap_epc", o_epc, 32'h20);
`else
        check("notrap_pc", o_pc, 32'h500);
        check("notrap_epc", o_epc, 32'h0);
`endif
        step();
        check("post_trap_valid", o_instr_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
